// File: rtl/dvfs_task_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : dvfs_task_dispatcher_if
// Description : Bundle of the assigner, regulator/clock and core handshake
//               signals seen by the DVFS task dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
interface dvfs_task_dispatcher_if #(
  parameter int N = 10,
  parameter int L = 8
);
  logic              assign_valid;
  logic [32*N-1:0]   assigned_f;
  logic [32*N-1:0]   M;
  logic [32*L-1:0]   f;
  logic [32*L-1:0]   v;
  logic [31:0]       freq_out;
  logic [31:0]       volt_out;
  logic [31:0]       cur_level;
  logic              task_valid;
  logic              task_ready;
  logic [31:0]       task_id;
  logic [31:0]       task_cycles;
  logic              task_done;
  logic              busy;
  logic              all_done;
  logic              err;

  // Dispatcher side
  modport master (
    input  assign_valid, assigned_f, M, f, v, task_ready, task_done,
    output freq_out, volt_out, cur_level, task_valid, task_id, task_cycles,
           busy, all_done, err
  );

  // Assigner / core / regulator side
  modport slave (
    output assign_valid, assigned_f, M, f, v, task_ready, task_done,
    input  freq_out, volt_out, cur_level, task_valid, task_id, task_cycles,
           busy, all_done, err
  );
endinterface
`default_nettype wire

// File: rtl/dvfs_task_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : dvfs_task_dispatcher
// Description : Latches a per-task level vector, applies each task's V/F level
//               with safe ordering and settle waits, then offers the task to
//               the core and waits for its completion.
// Revision    : 1.0 - initial release
// ============================================================================
module dvfs_task_dispatcher #(
  parameter int N             = 10,
  parameter int L             = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  dvfs_task_dispatcher_if.master bus
);

  localparam int              KW            = (N > 1) ? $clog2(N) : 1;
  localparam int              LW            = (L > 1) ? $clog2(L) : 1;
  localparam logic [KW-1:0]   C_LAST_K      = KW'(N - 1);
  localparam logic [31:0]     C_SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0]     C_NUM_LEVELS  = 32'(L);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LATCH    = 4'd1,
    S_CHECK    = 4'd2,
    S_SET_V1   = 4'd3,
    S_SET_F1   = 4'd4,
    S_WAIT1    = 4'd5,
    S_SET_F2   = 4'd6,
    S_SET_V2   = 4'd7,
    S_WAIT2    = 4'd8,
    S_DISPATCH = 4'd9,
    S_RUN      = 4'd10,
    S_DONE     = 4'd11
  } state_t;

  state_t        state_q;
  logic          av_q;          // previous assign_valid, for rising-edge detect
  logic          applied_ok_q;  // cur_level reflects a level actually applied
  logic          up_q;          // current transition ramps up (voltage first)
  logic [KW-1:0] k_q;
  logic [31:0]   lvl_q;
  logic [31:0]   cnt_q;
  logic [31:0]   af_q [N];
  logic [31:0]   m_q  [N];
  logic [31:0]   freq_q;
  logic [31:0]   volt_q;
  logic [31:0]   cur_level_q;
  logic          task_valid_q;
  logic [31:0]   task_id_q;
  logic [31:0]   task_cycles_q;
  logic          busy_q;
  logic          all_done_q;
  logic          err_q;

  logic [31:0]   w_af [N];
  logic [31:0]   w_m  [N];
  logic [31:0]   w_f  [L];
  logic [31:0]   w_v  [L];
  logic [31:0]   w_lvl;
  logic [LW-1:0] w_lvl_idx;
  logic          w_start;

  for (genvar gi = 0; gi < N; gi++) begin : g_task_unpack
    assign w_af[gi] = bus.assigned_f[32*gi +: 32];
    assign w_m[gi]  = bus.M[32*gi +: 32];
  end

  for (genvar gl = 0; gl < L; gl++) begin : g_level_unpack
    assign w_f[gl] = bus.f[32*gl +: 32];
    assign w_v[gl] = bus.v[32*gl +: 32];
  end

  assign w_lvl     = af_q[k_q];
  assign w_lvl_idx = lvl_q[LW-1:0];   // only used once lvl_q is known to be < L
  assign w_start   = bus.assign_valid & ~av_q;

  // Dispatch sequencer: latch, per-task V/F ordering with settle waits, handshake
  always_ff @(posedge clk) begin
    av_q       <= bus.assign_valid;
    all_done_q <= 1'b0;
    if (reset) begin
      state_q       <= S_IDLE;
      av_q          <= 1'b0;
      applied_ok_q  <= 1'b0;
      up_q          <= 1'b0;
      k_q           <= '0;
      lvl_q         <= '0;
      cnt_q         <= '0;
      freq_q        <= '0;
      volt_q        <= '0;
      cur_level_q   <= '0;
      task_valid_q  <= 1'b0;
      task_id_q     <= '0;
      task_cycles_q <= '0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      for (int i = 0; i < N; i++) begin
        af_q[i] <= '0;
        m_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_start) state_q <= S_LATCH;
        end
        S_LATCH: begin
          for (int i = 0; i < N; i++) begin
            af_q[i] <= w_af[i];
            m_q[i]  <= w_m[i];
          end
          k_q     <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          lvl_q <= w_lvl;
          if (w_lvl >= C_NUM_LEVELS) begin
            // Abort the whole batch; later tasks are never offered.
            err_q      <= 1'b1;
            all_done_q <= 1'b1;
            state_q    <= S_DONE;
          end else if ((w_lvl == cur_level_q) && applied_ok_q) begin
            task_valid_q  <= 1'b1;
            task_id_q     <= {{(32-KW){1'b0}}, k_q};
            task_cycles_q <= m_q[k_q];
            state_q       <= S_DISPATCH;
          end else if ((w_lvl > cur_level_q) || !applied_ok_q) begin
            up_q    <= 1'b1;
            state_q <= S_SET_V1;
          end else begin
            up_q    <= 1'b0;
            state_q <= S_SET_F1;
          end
        end
        S_SET_V1: begin
          volt_q  <= w_v[w_lvl_idx];
          cnt_q   <= C_SETTLE_LOAD;
          state_q <= S_WAIT1;
        end
        S_SET_F1: begin
          freq_q  <= w_f[w_lvl_idx];
          cnt_q   <= C_SETTLE_LOAD;
          state_q <= S_WAIT1;
        end
        S_WAIT1: begin
          if (cnt_q == '0) state_q <= up_q ? S_SET_F2 : S_SET_V2;
          else             cnt_q   <= cnt_q - 32'd1;
        end
        S_SET_F2: begin
          freq_q  <= w_f[w_lvl_idx];
          cnt_q   <= C_SETTLE_LOAD;
          state_q <= S_WAIT2;
        end
        S_SET_V2: begin
          volt_q  <= w_v[w_lvl_idx];
          cnt_q   <= C_SETTLE_LOAD;
          state_q <= S_WAIT2;
        end
        S_WAIT2: begin
          if (cnt_q == '0) begin
            cur_level_q   <= lvl_q;
            applied_ok_q  <= 1'b1;
            task_valid_q  <= 1'b1;
            task_id_q     <= {{(32-KW){1'b0}}, k_q};
            task_cycles_q <= m_q[k_q];
            state_q       <= S_DISPATCH;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_DISPATCH: begin
          // task_done here is ignored; only the accept matters.
          if (bus.task_ready) begin
            task_valid_q <= 1'b0;
            state_q      <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.task_done) begin
            if (k_q == C_LAST_K) begin
              all_done_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              k_q     <= k_q + 1'b1;
              state_q <= S_CHECK;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.freq_out    = freq_q;
  assign bus.volt_out    = volt_q;
  assign bus.cur_level   = cur_level_q;
  assign bus.task_valid  = task_valid_q;
  assign bus.task_id     = task_id_q;
  assign bus.task_cycles = task_cycles_q;
  assign bus.busy        = busy_q;
  assign bus.all_done    = all_done_q;
  assign bus.err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dvfs_task_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_dvfs_task_dispatcher
// Description : Self-checking bench for dvfs_task_dispatcher with a
//               transaction-level model of level ordering and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dvfs_task_dispatcher;

  localparam int N = 10;
  localparam int L = 8;
  localparam int S = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] af_m [N];
  logic [31:0] m_m  [N];
  logic [31:0] f_m  [L];
  logic [31:0] v_m  [L];
  logic [31:0] cur_m;
  bit          app_m;

  dvfs_task_dispatcher_if #(.N(N), .L(L)) bus ();

  dvfs_task_dispatcher #(.N(N), .L(L), .SETTLE_CYCLES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic load_tables();
    for (int i = 0; i < N; i++) begin
      bus.assigned_f[32*i +: 32] = af_m[i];
      bus.M[32*i +: 32]          = m_m[i];
    end
    for (int i = 0; i < L; i++) begin
      bus.f[32*i +: 32] = f_m[i];
      bus.v[32*i +: 32] = v_m[i];
    end
  endtask

  task automatic rand_tasks();
    for (int i = 0; i < N; i++) begin
      af_m[i] = $urandom_range(0, L-1);
      m_m[i]  = $urandom;
    end
  endtask

  // Applies one task starting at the negedge of its CHECK cycle; returns at the
  // negedge of the following CHECK (or DONE) cycle.
  task automatic serve_task(input int k, input int rdy_dly, input bit done_w_rdy,
                            input int abort_cyc, output bit aborted);
    logic [31:0] lvl, pf, pv;
    int kind, cyc, tv, tf, nch, e_cyc, e_tv, e_tf, nwait;
    lvl     = af_m[k];
    aborted = 1'b0;
    if (lvl == cur_m && app_m)       kind = 0;
    else if (lvl > cur_m || !app_m)  kind = 1;
    else                             kind = 2;
    pf = bus.freq_out; pv = bus.volt_out;
    cyc = 0; tv = -1; tf = -1; nch = 0;
    while (bus.task_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == abort_cyc) begin
        reset = 1'b1; bus.assign_valid = 1'b0; aborted = 1'b1;
        return;
      end
      if (bus.volt_out !== pv) begin nch++; if (tv < 0) tv = cyc; pv = bus.volt_out; end
      if (bus.freq_out !== pf) begin nch++; if (tf < 0) tf = cyc; pf = bus.freq_out; end
      for (int j = 0; j < L; j++) begin
        if (f_m[j] == bus.freq_out) begin
          n_cmp++;
          if (bus.volt_out < v_m[j]) begin
            n_bad++;
            $display("FAIL vf_safe task%0d: got volt %0d want >= %0d", k, bus.volt_out, v_m[j]);
          end
        end
      end
    end
    case (kind)
      0:       begin e_cyc = 1;       e_tv = -1;    e_tf = -1;    end
      1:       begin e_cyc = 3 + 2*S; e_tv = 2;     e_tf = 3 + S; end
      default: begin e_cyc = 3 + 2*S; e_tv = 3 + S; e_tf = 2;     end
    endcase
    n_cmp++;
    if (cyc != e_cyc) begin n_bad++; $display("FAIL latency task%0d: got %0d want %0d", k, cyc, e_cyc); end
    n_cmp++;
    if (tv != e_tv) begin n_bad++; $display("FAIL volt_time task%0d: got %0d want %0d", k, tv, e_tv); end
    n_cmp++;
    if (tf != e_tf) begin n_bad++; $display("FAIL freq_time task%0d: got %0d want %0d", k, tf, e_tf); end
    n_cmp++;
    if (nch != ((kind == 0) ? 0 : 2)) begin
      n_bad++; $display("FAIL vf_changes task%0d: got %0d want %0d", k, nch, (kind == 0) ? 0 : 2);
    end
    n_cmp++;
    if (bus.task_id !== k || bus.task_cycles !== m_m[k]) begin
      n_bad++;
      $display("FAIL offer task%0d: got id %0d cyc %h want id %0d cyc %h", k, bus.task_id, bus.task_cycles, k, m_m[k]);
    end
    n_cmp++;
    if (bus.freq_out !== f_m[lvl] || bus.volt_out !== v_m[lvl] || bus.cur_level !== lvl) begin
      n_bad++;
      $display("FAIL applied task%0d: got f %0d v %0d lvl %0d want f %0d v %0d lvl %0d", k,
               bus.freq_out, bus.volt_out, bus.cur_level, f_m[lvl], v_m[lvl], lvl);
    end
    cur_m = lvl; app_m = 1'b1;
    // Stall the core; stray task_done pulses outside RUN must be ignored.
    for (int d = 0; d < rdy_dly; d++) begin
      bus.task_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_cmp++;
      if (bus.task_valid !== 1'b1 || bus.task_id !== k || bus.task_cycles !== m_m[k]) begin
        n_bad++;
        $display("FAIL offer_stable task%0d: got v %0b id %0d want v 1 id %0d", k, bus.task_valid, bus.task_id, k);
      end
    end
    bus.task_ready = 1'b1;
    bus.task_done  = done_w_rdy;
    @(negedge clk);
    bus.task_ready = 1'b0;
    bus.task_done  = 1'b0;
    n_cmp++;
    if (bus.task_valid !== 1'b0) begin n_bad++; $display("FAIL accept task%0d: got valid %0b want 0", k, bus.task_valid); end
    nwait = $urandom_range(0, 3);
    for (int w = 0; w < nwait; w++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.task_valid !== 1'b0 || bus.all_done !== 1'b0) begin
        n_bad++; $display("FAIL run_idle task%0d: got valid %0b done %0b want 0 0", k, bus.task_valid, bus.all_done);
      end
    end
    bus.task_done = 1'b1;
    @(negedge clk);
    bus.task_done = 1'b0;
  endtask

  task automatic run_sequence(input int abort_task, input int abort_cyc,
                              input int stall_task, input int stall_len);
    int bad_k;
    bit ab, exp_err;
    bad_k = -1;
    for (int i = 0; i < N; i++) if (bad_k < 0 && af_m[i] >= 32'(L)) bad_k = i;
    exp_err = (bad_k >= 0);
    load_tables();
    bus.assign_valid = 1'b0;
    @(negedge clk);
    bus.assign_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin
      n_bad++; $display("FAIL start: got busy %0b err %0b want 1 0", bus.busy, bus.err);
    end
    ab = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k == bad_k) begin @(negedge clk); break; end
      serve_task(k, (k == stall_task) ? stall_len : int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), (k == abort_task) ? abort_cyc : 0, ab);
      if (ab) break;
    end
    if (ab) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.freq_out, bus.volt_out, bus.cur_level, bus.task_id, bus.task_cycles,
           bus.task_valid, bus.busy, bus.all_done, bus.err} !== '0) begin
        n_bad++;
        $display("FAIL mid_reset: got f %0d v %0d lvl %0d valid %0b busy %0b want all 0",
                 bus.freq_out, bus.volt_out, bus.cur_level, bus.task_valid, bus.busy);
      end
      reset = 1'b0; cur_m = '0; app_m = 1'b0;
      return;
    end
    n_cmp++;
    if (bus.all_done !== 1'b1 || bus.busy !== 1'b1 || bus.task_valid !== 1'b0 || bus.err !== exp_err) begin
      n_bad++;
      $display("FAIL done_cycle: got done %0b busy %0b valid %0b err %0b want 1 1 0 %0b",
               bus.all_done, bus.busy, bus.task_valid, bus.err, exp_err);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.all_done !== 1'b0 || bus.busy !== 1'b0 || bus.err !== exp_err || bus.task_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL after_done: got done %0b busy %0b err %0b want 0 0 %0b", bus.all_done, bus.busy, bus.err, exp_err);
    end
  endtask

  task automatic test_reset();
    f_m = '{100, 200, 300, 450, 600, 800, 1000, 1200};
    v_m = '{6, 8, 9, 10, 11, 12, 14, 16};
    rand_tasks();
    load_tables();
    reset = 1'b1; bus.assign_valid = 1'b1; bus.task_ready = 1'b0; bus.task_done = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.freq_out, bus.volt_out, bus.cur_level, bus.task_id, bus.task_cycles,
         bus.task_valid, bus.busy, bus.all_done, bus.err} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got busy %0b valid %0b f %0d want all 0", bus.busy, bus.task_valid, bus.freq_out);
    end
    bus.assign_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.task_valid, bus.busy, bus.all_done, bus.err, bus.freq_out} !== '0) begin
      n_bad++; $display("FAIL idle_after_reset: got busy %0b valid %0b want 0 0", bus.busy, bus.task_valid);
    end
    cur_m = '0; app_m = 1'b0;
  endtask

  task automatic test_basic();
    rand_tasks();
    af_m[0] = 2; af_m[1] = 5; af_m[2] = 5; af_m[3] = 1;
    run_sequence(-1, 0, -1, 0);
  endtask

  task automatic test_ramp_down();
    rand_tasks();
    af_m[0] = 5; af_m[1] = 1;
    run_sequence(-1, 0, -1, 0);
  endtask

  task automatic test_ready_stall();
    rand_tasks();
    run_sequence(-1, 0, $urandom_range(0, N-1), 20);
  endtask

  task automatic test_bad_level();
    rand_tasks();
    af_m[3] = 9;
    run_sequence(-1, 0, -1, 0);
  endtask

  task automatic test_reset_mid();
    rand_tasks();
    af_m[0] = 3; af_m[1] = 6; af_m[2] = 2;
    run_sequence(2, 3, -1, 0);
    rand_tasks();
    af_m[0] = 3;
    run_sequence(-1, 0, -1, 0);
  endtask

  task automatic test_held_valid();
    rand_tasks();
    run_sequence(-1, 0, -1, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.task_valid !== 1'b0 || bus.all_done !== 1'b0) begin
        n_bad++; $display("FAIL held_valid: got busy %0b valid %0b want 0 0", bus.busy, bus.task_valid);
      end
    end
    rand_tasks();
    run_sequence(-1, 0, -1, 0);
  endtask

  task automatic test_random();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cur_m = '0; app_m = 1'b0;
    f_m[0] = $urandom_range(50, 150);
    v_m[0] = $urandom_range(1, 10);
    for (int i = 1; i < L; i++) begin
      f_m[i] = f_m[i-1] + $urandom_range(1, 200);
      v_m[i] = v_m[i-1] + $urandom_range(1, 5);
    end
    for (int it = 0; it < 6; it++) begin
      rand_tasks();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 14) == 0) begin
          case ($urandom_range(0, 2))
            0:       af_m[i] = 32'(L);
            1:       af_m[i] = 32'(L + 3);
            default: af_m[i] = 32'hFFFF_FFFF;
          endcase
        end
      end
      run_sequence(-1, 0, -1, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.assign_valid = 1'b0;
    bus.task_ready   = 1'b0;
    bus.task_done    = 1'b0;
    cur_m = '0; app_m = 1'b0;
    test_reset();
    test_basic();
    test_ramp_down();
    test_ready_stall();
    test_bad_level();
    test_reset_mid();
    test_held_valid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
